// File: rtl/slowclk_meter_if.sv
// Measurement bundle between a slow-strobe source and its fastclk consumer.
// The source side drives slowin; the meter returns tick, measurements and status flags.
interface slowclk_meter_if #(
    parameter int CNT_W = 28
);
    logic             slowin;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] hightime;
    logic             period_stb;
    logic             period_valid;
    logic             stalled;

    modport master (
        output slowin,
        input  tick, period, hightime, period_stb, period_valid, stalled
    );

    modport slave (
        input  slowin,
        output tick, period, hightime, period_stb, period_valid, stalled
    );
endinterface

// File: rtl/slowclk_meter.sv
// Synchronises a slow square wave into fastclk, pulses tick per rising edge, measures period/high time and flags stalls.
// Input rise to tick takes 2-3 cycles. There is no backpressure: strobes are single-cycle and must be consumed when they fire.
module slowclk_meter #(
    parameter int CNT_W   = 28,
    parameter int TIMEOUT = 200000000
) (
    input  logic          fastclk,
    input  logic          rst,
    slowclk_meter_if.slave mif
);
    typedef enum logic [1:0] {PRIME, WAIT_FIRST, RUN, STALL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic             s1, s2, s3;
    logic             rise;
    logic [1:0]       prime_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic             timeout_hit;
    logic             accept;
    logic             capture;
    logic             count_en;

    logic             tick_q;
    logic             stb_q;
    logic             valid_q;
    logic             stalled_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] hightime_q;

    always_ff @(posedge fastclk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mif.slowin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise        = s2 & ~s3;
    assign timeout_hit = (cnt == TIMEOUT_C);

    always_ff @(posedge fastclk) begin
        if (rst) begin
            state <= PRIME;
        end else begin
            state <= state_nxt;
        end
    end

    // A rise always beats a simultaneous timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            PRIME:      if (prime_cnt == 2'd2) state_nxt = WAIT_FIRST;
            WAIT_FIRST: if (rise) state_nxt = RUN;
                        else if (timeout_hit) state_nxt = STALL;
            RUN:        if (!rise && timeout_hit) state_nxt = STALL;
            STALL:      if (rise) state_nxt = RUN;
            default:    state_nxt = PRIME;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        capture  = 1'b0;
        count_en = 1'b0;
        case (state)
            WAIT_FIRST: begin
                accept   = rise;
                count_en = !rise && !timeout_hit;
            end
            RUN: begin
                accept   = rise;
                capture  = rise;
                count_en = !rise && !timeout_hit;
            end
            STALL:      accept = rise;
            default: ;
        endcase
    end

    always_ff @(posedge fastclk) begin
        if (rst) begin
            prime_cnt  <= 2'd0;
            cnt        <= '0;
            hi_cnt     <= '0;
            tick_q     <= 1'b0;
            stb_q      <= 1'b0;
            valid_q    <= 1'b0;
            stalled_q  <= 1'b0;
            period_q   <= '0;
            hightime_q <= '0;
        end else begin
            prime_cnt <= (state == PRIME) ? prime_cnt + 2'd1 : 2'd0;
            tick_q    <= accept;
            stb_q     <= capture;
            stalled_q <= (state_nxt == STALL);

            if (accept) begin
                cnt    <= CNT_W'(1);
                hi_cnt <= CNT_W'(1);
            end else if (count_en) begin
                if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                if (s2 && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CNT_W'(1);
            end

            // Measurements persist through a stall; only the valid flag goes stale.
            if (capture) begin
                period_q   <= cnt;
                hightime_q <= hi_cnt;
                valid_q    <= 1'b1;
            end else if (state_nxt == STALL) begin
                valid_q    <= 1'b0;
            end
        end
    end

    assign mif.tick         = tick_q;
    assign mif.period       = period_q;
    assign mif.hightime     = hightime_q;
    assign mif.period_stb   = stb_q;
    assign mif.period_valid = valid_q;
    assign mif.stalled      = stalled_q;
endmodule

// File: tb/tb_slowclk_meter.sv
// Randomised bench for slowclk_meter against an edge-arithmetic reference model.
module tb_slowclk_meter;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 100;
    localparam int MAXC    = 16384;

    logic fastclk = 1'b0;
    logic rst     = 1'b1;

    always #5 fastclk = ~fastclk;

    slowclk_meter_if #(.CNT_W(CNT_W)) mif ();

    slowclk_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .fastclk (fastclk),
        .rst     (rst),
        .mif     (mif)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: effective input sample taken at each edge, plus event bookkeeping.
    bit smp [0:MAXC-1];
    int cyc = 0;
    int rel_edge = 0;     // first edge with reset released
    int base = 0;         // edge at which the idle count was zero
    int last = -1;        // edge of last accepted rise
    bit prev_ok = 0;      // last accepted rise opened an unbroken measurement
    bit m_tick = 0, m_stb = 0, m_valid = 0, m_stalled = 0;
    int m_period = 0, m_high = 0;
    int rst_at = -1;
    int tick_cnt = 0, stb_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit smp_at(input int j);
        return (j < 0) ? 1'b0 : smp[j];
    endfunction

    task automatic model_edge(input bit r, input bit s);
        bit rise;
        bit accept;
        int e;
        cyc++;
        e = cyc;
        m_tick = 0;
        m_stb  = 0;
        if (r) begin
            for (int j = e - 2; j <= e; j++) if (j >= 0) smp[j] = 1'b0;
            rel_edge  = e + 1;
            base      = rel_edge + 2;
            last      = -1;
            prev_ok   = 0;
            m_valid   = 0;
            m_stalled = 0;
            m_period  = 0;
            m_high    = 0;
            return;
        end
        smp[e] = s;
        rise   = smp_at(e - 2) && !smp_at(e - 3);
        accept = rise && (e >= rel_edge + 3);
        if (accept) begin
            m_tick = 1;
            if (prev_ok) begin
                m_period = e - last;
                m_high   = 0;
                for (int j = last - 2; j <= e - 3; j++) m_high += smp_at(j);
                m_stb    = 1;
                m_valid  = 1;
            end
            last      = e;
            prev_ok   = 1;
            m_stalled = 0;
            base      = e - 1;
        end else if (!m_stalled && e >= rel_edge + 3 && (e - 1 - base) >= TIMEOUT) begin
            m_stalled = 1;
            m_valid   = 0;
            prev_ok   = 0;
        end
    endtask

    task automatic step(input bit r, input bit s);
        bit r_eff;
        r_eff      = r || (cyc + 1 == rst_at);
        rst        = r_eff;
        mif.slowin = s;
        @(posedge fastclk);
        model_edge(r_eff, s);
        #1;
        if (mif.tick === 1'b1) tick_cnt++;
        if (mif.period_stb === 1'b1) stb_cnt++;
        check("tick",         mif.tick,         m_tick);
        check("period_stb",   mif.period_stb,   m_stb);
        check("period",       mif.period,       m_period);
        check("hightime",     mif.hightime,     m_high);
        check("period_valid", mif.period_valid, m_valid);
        check("stalled",      mif.stalled,      m_stalled);
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            repeat (hi) step(1'b0, 1'b1);
            repeat (lo) step(1'b0, 1'b0);
        end
    endtask

    initial begin
        int hi, lo;
        mif.slowin = 1'b1;

        // Input held high through and after reset: never a tick, stall after timeout.
        repeat (3) step(1'b1, 1'b1);
        tick_cnt = 0;
        repeat (130) step(1'b0, 1'b1);
        check("hold_hi_ticks", tick_cnt, 0);
        check("hold_hi_stalled", mif.stalled, 1);

        // 20/10 square wave with random starting phase.
        repeat ($urandom_range(5, 12)) step(1'b0, 1'b0);
        tick_cnt = 0;
        wave(10, 10, 8);
        check("sq20_ticks", tick_cnt, 8);
        check("sq20_period", mif.period, 20);
        check("sq20_high", mif.hightime, 10);
        check("sq20_valid", mif.period_valid, 1);

        // Divider switch to 40/20.
        wave(20, 20, 6);
        check("sq40_period", mif.period, 40);
        check("sq40_high", mif.hightime, 20);

        // Input stops low.
        repeat (150) step(1'b0, 1'b0);
        check("stop_stalled", mif.stalled, 1);
        check("stop_valid", mif.period_valid, 0);

        // Resume: first rise clears stall without a strobe.
        tick_cnt = 0;
        stb_cnt  = 0;
        wave(10, 10, 1);
        check("resume_ticks", tick_cnt, 1);
        check("resume_strobes", stb_cnt, 0);
        check("resume_stalled", mif.stalled, 0);
        wave(10, 10, 3);
        check("resume_period", mif.period, 20);

        // One-cycle reset in the middle of a run.
        rst_at = cyc + 25;
        wave(10, 10, 6);
        rst_at = -1;
        check("rst_mid_period", mif.period, 20);
        check("rst_mid_valid", mif.period_valid, 1);

        // Rise landing exactly on the timeout count.
        wave(50, 50, 4);
        check("edge_to_period", mif.period, 100);
        check("edge_to_stalled", mif.stalled, 0);
        check("edge_to_valid", mif.period_valid, 1);

        // Random pulse trains with occasional long gaps and resets.
        repeat (40) begin
            hi = $urandom_range(2, 30);
            lo = ($urandom_range(0, 7) == 0) ? $urandom_range(90, 130) : $urandom_range(2, 30);
            if ($urandom_range(0, 15) == 0) rst_at = cyc + $urandom_range(1, hi + lo);
            wave(hi, lo, 1);
        end
        repeat (10) step(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
